// File: rtl/fft_spectrum_reader.sv
// Power/peak reader at the FFT output: streams re^2+im^2 per bin and reports the frame peak.
// Optional macro FFT_READER_SKIP_DC_EN removes bin 0 from the peak search.
module fft_spectrum_reader #(
  parameter int unsigned FFT_SIZE      = 1024,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned HALF_SPECTRUM = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        fft_in_valid_i,
  input  logic [2*DATA_WIDTH-1:0]     fft_in_data_i,
  output logic                        fft_in_ready_o,
  output logic                        pwr_valid_o,
  output logic [2*DATA_WIDTH-1:0]     pwr_data_o,
  output logic [$clog2(FFT_SIZE)-1:0] pwr_bin_o,
  output logic                        pwr_last_o,
  input  logic                        pwr_ready_i,
  output logic                        peak_valid_o,
  output logic [$clog2(FFT_SIZE)-1:0] peak_bin_o,
  output logic [2*DATA_WIDTH-1:0]     peak_pwr_o,
  input  logic                        peak_ready_i,
  output logic [15:0]                 frame_cnt_o
);

  localparam int unsigned BinW = $clog2(FFT_SIZE);
  localparam int unsigned PwrW = 2 * DATA_WIDTH;
  localparam logic [BinW-1:0] LastBin = BinW'(FFT_SIZE - 1);
  localparam logic [BinW-1:0] HalfBin = BinW'(FFT_SIZE / 2);

  typedef enum logic {StRecv, StReport} state_e;

  state_e            state_q, state_d;
  logic [BinW-1:0]   bin_q;
  logic              pwr_valid_q;
  logic [PwrW-1:0]   pwr_data_q;
  logic [BinW-1:0]   pwr_bin_q;
  logic              pwr_last_q;
  logic              run_valid_q, run_valid_d;
  logic [BinW-1:0]   run_bin_q, run_bin_d;
  logic [PwrW-1:0]   run_pwr_q, run_pwr_d;
  logic              peak_valid_q;
  logic [BinW-1:0]   peak_bin_q;
  logic [PwrW-1:0]   peak_pwr_q;
  logic [15:0]       frame_cnt_q;

  logic                         accept, last_accept, peak_hs, eligible;
  logic signed [DATA_WIDTH-1:0] re, im;
  logic signed [PwrW-1:0]       re_ext, im_ext, re_sq, im_sq;
  logic [PwrW-1:0]              pwr;

  assign fft_in_ready_o = rst_ni && (state_q == StRecv) && (!pwr_valid_q || pwr_ready_i);
  assign accept         = fft_in_valid_i && fft_in_ready_o;
  assign last_accept    = accept && (bin_q == LastBin);
  assign peak_hs        = peak_valid_q && peak_ready_i;

  // Full-width signed squares; the sum peaks at 2^(PwrW-1), so it cannot wrap.
  assign re     = fft_in_data_i[PwrW-1:DATA_WIDTH];
  assign im     = fft_in_data_i[DATA_WIDTH-1:0];
  assign re_ext = PwrW'(re);
  assign im_ext = PwrW'(im);
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign pwr    = $unsigned(re_sq) + $unsigned(im_sq);

  always_comb begin
    eligible = (HALF_SPECTRUM == 0) || (bin_q < HalfBin);
`ifdef FFT_READER_SKIP_DC_EN
    if (bin_q == '0) eligible = 1'b0;
`endif
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    run_valid_d = run_valid_q;
    run_bin_d   = run_bin_q;
    run_pwr_d   = run_pwr_q;
    if (accept && eligible && (!run_valid_q || (pwr > run_pwr_q))) begin
      run_valid_d = 1'b1;
      run_bin_d   = bin_q;
      run_pwr_d   = pwr;
    end
    if (peak_hs) begin
      run_valid_d = 1'b0;
      run_bin_d   = '0;
      run_pwr_d   = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRecv:   if (last_accept) state_d = StReport;
      StReport: if (peak_hs) state_d = StRecv;
      default:  state_d = StRecv;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StRecv;
      bin_q        <= '0;
      pwr_valid_q  <= 1'b0;
      pwr_data_q   <= '0;
      pwr_bin_q    <= '0;
      pwr_last_q   <= 1'b0;
      run_valid_q  <= 1'b0;
      run_bin_q    <= '0;
      run_pwr_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_pwr_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_valid_q <= run_valid_d;
      run_bin_q   <= run_bin_d;
      run_pwr_q   <= run_pwr_d;
      if (accept) begin
        bin_q       <= (bin_q == LastBin) ? '0 : bin_q + 1'b1;
        pwr_valid_q <= 1'b1;
        pwr_data_q  <= pwr;
        pwr_bin_q   <= bin_q;
        pwr_last_q  <= (bin_q == LastBin);
      end else if (pwr_ready_i) begin
        pwr_valid_q <= 1'b0;
      end
      // Report is captured from the next-state peak so the last bin is included.
      if (last_accept) begin
        peak_valid_q <= 1'b1;
        peak_bin_q   <= run_bin_d;
        peak_pwr_q   <= run_pwr_d;
      end else if (peak_hs) begin
        peak_valid_q <= 1'b0;
        frame_cnt_q  <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign pwr_valid_o  = pwr_valid_q;
  assign pwr_data_o   = pwr_data_q;
  assign pwr_bin_o    = pwr_bin_q;
  assign pwr_last_o   = pwr_last_q;
  assign peak_valid_o = peak_valid_q;
  assign peak_bin_o   = peak_bin_q;
  assign peak_pwr_o   = peak_pwr_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule
